gate_bist_cell: RTL
===================

# gate_bist_cell

Parametrised N-input CMOS-style logic cell. The gate function (AND/NAND/OR/NOR/XOR/XNOR) is selectable at run time, and the output is registered. A built-in self-test (BIST) sequencer sweeps all 2^N input vectors through the gate core and compares each result against a golden reduction, so a test can prove the cell exhaustively. A fault-injection port lets the bench confirm the checker actually detects defects. The cell is the clocked, testable successor to the primitive switch-level gates in the library.

## Interface
- N, default 2: number of gate inputs, legal range 1..8.
- CNT_W, default 8: width of the mismatch counter, legal range 1..16.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- mode, input, 3: gate function.
  - 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR.
  - 110 and 111 decode as AND.
- in, input, N: functional inputs; in[0] is the LSB.
- fault_sel, input, 2: fault injected into the gate core (never into the golden model).
  - 00 none.
  - 01 core output stuck-at-0.
  - 10 core output stuck-at-1.
  - 11 core input in[0] stuck-at-0.
- start, input, 1: request a BIST sweep; level-sampled in IDLE only.
- y, output, 1: registered core output.
- busy, output, 1: high while the sweep runs.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: result of the last completed sweep.
- err_cnt, output, CNT_W: number of mismatches in the last or current sweep.

## Operation
State machine states: IDLE, RUN, DONE.

- IDLE
  - The core is driven from `in` with the live `mode`.
  - y <= core(in) every cycle.
  - If start=1 at an edge:
    - latch mode into mode_q;
    - clear err_cnt and pass;
    - vec <= 0;
    - go to RUN.
- RUN
  - The core is driven from vec (N bits) with mode_q.
  - y <= core(vec).
  - golden = reduction of the un-faulted vec under mode_q.
  - If core(vec) != golden, err_cnt increments, saturating at 2^CNT_W-1 (never wraps).
  - vec increments each cycle.
  - When vec == 2^N-1 the state goes to DONE at the next edge; that vector is still compared.
  - start, mode and in are ignored.
- DONE
  - Lasts exactly one cycle.
  - done=1 and pass=(err_cnt==0).
  - Next state is IDLE.
  - start asserted during DONE is ignored; it is only sampled in IDLE.
- Result persistence: pass and err_cnt hold until the next accepted start or reset.
- fault_sel is live in every state. The bench holds it stable across a sweep; a change mid-sweep affects only the vectors compared after the change.
- Internal width: vec is N+1 bits wide, so the terminal compare works for N=8.
- N=1: XOR/XNOR degenerate to buffer/inverter, AND/OR to buffer, NAND/NOR to inverter.

## Timing
- Reset values: y=0, busy=0, done=0, pass=0, err_cnt=0, state=IDLE, vec=0, mode_q=000.
- Reset is asynchronous. Asserting rst_n mid-sweep aborts it immediately: no done pulse, and pass/err_cnt are cleared.
- Normal-mode latency: 1 cycle from in/mode to y.
- Sweep timeline, with start sampled at edge 0:
  - busy=1 from after edge 1 through edge 2^N, i.e. exactly 2^N cycles.
  - done=1 for the single cycle after edge 2^N+1.
  - Total sweep: 2^N+1 cycles from acceptance to done.
- busy falls in the same cycle done rises.
- The final err_cnt is valid when done=1.
- Back-to-back: start held high restarts a sweep from the edge after done (IDLE is one cycle).
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
1. Reset: hold rst_n=0 with random inputs, then release -> y=0, busy=0, done=0, pass=0, err_cnt=0.
2. Normal mode, N=2, mode=001 (NAND):
   - in=11 -> y=0 one cycle later.
   - in=01 -> y=1.
   - change mode to 100 (XOR) with in=01 -> y=1.
3. Clean sweep, N=2, mode=010 (OR), fault_sel=00, one-cycle start -> busy high 4 cycles, done pulse at edge 5, pass=1, err_cnt=0.
4. Stuck-at faults, N=2:
   - mode=000 (AND), fault_sel=01 -> err_cnt=1, pass=0.
   - mode=011 (NOR), fault_sel=10 -> err_cnt=3, pass=0.
5. Input fault, N=2, mode=100 (XOR), fault_sel=11 -> mismatches on vectors 01 and 11; err_cnt=2, pass=0. Also change mode mid-sweep -> no effect on the result.
6. Saturation and abort, N=8, CNT_W=4, mode=000 (AND), fault_sel=10:
   - Full sweep -> 255 mismatches; err_cnt=15, pass=0, busy 256 cycles.
   - Rerun and pull rst_n low at cycle 100 -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/gate_bist_cell.sv
// N-input logic cell with run-time selectable function, registered output, and an
// exhaustive BIST sweep that checks a fault-injectable core against an un-faulted golden reduction.
module gate_bist_cell #(
   parameter int N     = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       mode,
   input  logic [N-1:0]     in,
   input  logic [1:0]       fault_sel,
   input  logic             start,
   output logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int LAST_VEC = (1 << N) - 1;

   state_t           state_q, state_d;
   logic [N:0]       vec_q, vec_d;
   logic [2:0]       mode_q, mode_d;
   logic             y_q, y_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [N-1:0]     core_in;
   logic [2:0]       core_mode;
   logic             core_out;
   logic             golden;

   function automatic logic reduce_f(input logic [2:0] m, input logic [N-1:0] x);
      logic r;
      case (m)
         3'b001:  r = ~(&x);
         3'b010:  r = |x;
         3'b011:  r = ~(|x);
         3'b100:  r = ^x;
         3'b101:  r = ~(^x);
         default: r = &x;
      endcase
      return r;
   endfunction

   // Faults are applied to the core path only; the golden reduction always sees the clean vector.
   always_comb begin
      core_in   = (state_q == RUN) ? vec_q[N-1:0] : in;
      core_mode = (state_q == RUN) ? mode_q : mode;
      if (fault_sel == 2'b11) core_in[0] = 1'b0;
      core_out = reduce_f(core_mode, core_in);
      if (fault_sel == 2'b01) core_out = 1'b0;
      if (fault_sel == 2'b10) core_out = 1'b1;
      golden = reduce_f(mode_q, vec_q[N-1:0]);
   end

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      mode_d    = mode_q;
      y_d       = y_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = pass_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            y_d = core_out;
            if (start) begin
               mode_d    = mode;
               err_cnt_d = '0;
               pass_d    = 1'b0;
               vec_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            y_d    = core_out;
            busy_d = 1'b1;
            if ((core_out != golden) && (err_cnt_q != {CNT_W{1'b1}}))
               err_cnt_d = err_cnt_q + CNT_W'(1);
            vec_d = vec_q + (N+1)'(1);
            if (vec_q == (N+1)'(LAST_VEC)) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         mode_q    <= 3'b000;
         y_q       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         mode_q    <= mode_d;
         y_q       <= y_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign y       = y_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_cnt_q;

endmodule
